memunit: RTL and testbench
==========================

# memunit

Load/store unit that initiates transactions on the core's Membus as the master-side counterpart of the memory-mapped responders (RAM, ACLINT registers). It accepts one load or store per operation from the execute stage, stalls the pipeline until the responder completes the handshake, aligns write data and byte masks to the 32-bit bus, and sign- or zero-extends read data back to the pipeline.

## Interface
- XLEN, 32: width of the pipeline data and address.
- MEM_DATA_WIDTH, 32: Membus data width. Fixed at 4 byte lanes.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- valid  in  1  the execute stage holds an instruction this cycle.
- is_load  in  1  the instruction is a load.
- is_store  in  1  the instruction is a store.
- funct3  in  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  XLEN  byte address.
- wdata  in  XLEN  store data, right-aligned.
- stall  out  1  the pipeline must hold. Inputs must stay stable while this is high.
- rdata  out  XLEN  extended load result. Valid in the cycle the operation completes.
- error  out  1  one-cycle pulse for a misaligned access or an illegal funct3. No bus access is made.
- membus.valid  out  1  request valid.
- membus.ready  in  1  responder accepts the request.
- membus.addr  out  XLEN  word-aligned address (addr with [1:0] cleared).
- membus.wen  out  1  1 = write.
- membus.wdata  out  32  lane-aligned write data.
- membus.wmask  out  4  byte enables.
- membus.rvalid  in  1  response valid. Asserted for both reads and writes.
- membus.rdata  in  32  read data.

## Operation
- FSM states: INIT, WAIT_READY, WAIT_VALID.
- Request: req = valid & (is_load | is_store).
- Legality checks:
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Illegal funct3: 011, 110, 111.
  - Either case in INIT: error=1 for that cycle, stall=0, FSM stays in INIT, membus untouched.
- Legal request in INIT:
  - Register the bus fields: addr, wen=is_store, lane-shifted wdata, wmask.
  - Register funct3 and addr[1:0] for read extraction.
  - Go to WAIT_READY.
- Write lane alignment:
  - B: wdata[7:0] replicated to all lanes; wmask = 0001 << addr[1:0].
  - H: wdata[15:0] in both halves; wmask = 0011 << addr[1:0].
  - W: wdata as is; wmask = 1111.
  - For loads, wmask is 0000.
- WAIT_READY: membus.valid=1 with the registered fields. When ready=1, go to WAIT_VALID.
- WAIT_VALID: membus.valid=0. When rvalid=1, go to INIT. rdata is extracted combinationally from membus.rdata:
  - B: byte at lane addr[1:0], sign-extended.
  - BU: the same byte, zero-extended.
  - H / HU: halfword at addr[1], sign- / zero-extended.
  - W: the word as is.
  - Stores: rdata is 0.
- stall = (INIT & legal req) | WAIT_READY | (WAIT_VALID & ~rvalid).
- Only one outstanding transaction at a time. No pipelining of requests.

## Timing
- Reset values (asynchronous, effective immediately):
  - FSM goes to INIT.
  - membus.valid=0; addr, wdata, wmask and wen are 0.
  - stall=0, error=0, rdata=0.
- Reset mid-operation abandons the transaction. A late ready or rvalid seen in INIT is ignored.
- Latency with a zero-wait responder (ready=1, rvalid one cycle after valid):
  - Cycle 0: request presented, stall=1.
  - Cycle 1: membus.valid=1, accepted.
  - Cycle 2: rvalid=1, stall=0, rdata valid.
  - Total: 3 cycles.
- Wait states:
  - ready low for N cycles extends WAIT_READY by N cycles. Valid and the fields stay stable.
  - rvalid low for M cycles extends WAIT_VALID by M cycles.
- rvalid in WAIT_READY is ignored. ready in WAIT_VALID is ignored.
- A new request can start in the cycle after completion. It cannot start in the completion cycle.

## Test plan
- Word load: addr=0x1000, funct3=010, responder returns 0xDEADBEEF -> membus.addr=0x1000, wen=0, wmask=0000; rdata=0xDEADBEEF on cycle 2; stall high for exactly cycles 0-1.
- Byte loads: LB at addr=0x1003 with bus rdata 0x80FF_0000 -> rdata=0xFFFFFF80. LBU at the same address -> rdata=0x00000080.
- Stores:
  - SH at addr=0x2002, wdata=0x1234ABCD -> membus.wdata=0xABCDABCD, wmask=1100, wen=1.
  - SB at 0x2001, wdata=0x55 -> wmask=0010.
- Misaligned and illegal:
  - LW at 0x1002 -> error=1 for one cycle, stall=0, membus.valid never asserted.
  - funct3=011 -> same response.
- Backpressure: ready held low 3 cycles, then rvalid delayed 2 cycles -> membus.valid high 4 cycles with stable fields; stall released only in the rvalid cycle.
- Reset mid-op: rst low during WAIT_READY -> membus.valid=0 immediately and FSM in INIT after release. A stray rvalid afterwards -> no stall change, rdata=0.

Source files
------------

// File: rtl/memunit_if.sv
// Membus: single-outstanding request/response bus between the load/store unit and
// memory-mapped responders (RAM, ACLINT registers).
interface memunit_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned MEM_DATA_WIDTH = 32
);
  logic                          valid;
  logic                          ready;
  logic [XLEN-1:0]               addr;
  logic                          wen;
  logic [MEM_DATA_WIDTH-1:0]     wdata;
  logic [MEM_DATA_WIDTH/8-1:0]   wmask;
  logic                          rvalid;
  logic [MEM_DATA_WIDTH-1:0]     rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/memunit.sv
// Load/store unit: issues one Membus transaction per load/store, stalls the pipeline
// until the responder completes, lane-aligns stores and extends loads.
module memunit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned MEM_DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            error,
  memunit_if.master       membus
);

  typedef enum logic [1:0] {StInit, StWaitReady, StWaitValid} state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]           addr_q;
  logic                      wen_q;
  logic [MEM_DATA_WIDTH-1:0] wdata_q;
  logic [3:0]                wmask_q;
  logic [2:0]                funct3_q;
  logic [1:0]                off_q;

  logic                      req;
  logic                      illegal;
  logic                      misaligned;
  logic                      load_en;
  logic [MEM_DATA_WIDTH-1:0] lane_wdata;
  logic [3:0]                lane_wmask;
  logic [7:0]                rbyte;
  logic [15:0]               rhalf;
  logic [XLEN-1:0]           ext;

  // Request decode and legality
  always_comb begin
    req        = valid & (is_load | is_store);
    illegal    = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = |addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Store lane alignment; loads never enable any byte
  always_comb begin
    lane_wdata = wdata[MEM_DATA_WIDTH-1:0];
    lane_wmask = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        lane_wdata = {4{wdata[7:0]}};
        lane_wmask = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{wdata[15:0]}};
        lane_wmask = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
    if (!is_store) lane_wmask = 4'b0000;
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    error   = 1'b0;
    load_en = 1'b0;
    unique case (state_q)
      StInit: begin
        if (req) begin
          if (illegal || misaligned) begin
            error = 1'b1;
          end else begin
            load_en = 1'b1;
            stall   = 1'b1;
            state_d = StWaitReady;
          end
        end
      end
      StWaitReady: begin
        stall = 1'b1;
        if (membus.ready) state_d = StWaitValid;
      end
      StWaitValid: begin
        if (membus.rvalid) state_d = StInit;
        else               stall   = 1'b1;
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StInit;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      funct3_q <= '0;
      off_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load_en) begin
        addr_q   <= {addr[XLEN-1:2], 2'b00};
        wen_q    <= is_store;
        wdata_q  <= lane_wdata;
        wmask_q  <= lane_wmask;
        funct3_q <= funct3;
        off_q    <= addr[1:0];
      end
    end
  end

  assign membus.valid = (state_q == StWaitReady);
  assign membus.addr  = addr_q;
  assign membus.wen   = wen_q;
  assign membus.wdata = wdata_q;
  assign membus.wmask = wmask_q;

  // Read extraction from the live bus word, using the latched size and offset
  always_comb begin
    case (off_q)
      2'd0:    rbyte = membus.rdata[7:0];
      2'd1:    rbyte = membus.rdata[15:8];
      2'd2:    rbyte = membus.rdata[23:16];
      default: rbyte = membus.rdata[31:24];
    endcase
    rhalf = off_q[1] ? membus.rdata[31:16] : membus.rdata[15:0];
    case (funct3_q)
      3'b000:  ext = {{(XLEN-8){rbyte[7]}}, rbyte};
      3'b100:  ext = {{(XLEN-8){1'b0}}, rbyte};
      3'b001:  ext = {{(XLEN-16){rhalf[15]}}, rhalf};
      3'b101:  ext = {{(XLEN-16){1'b0}}, rhalf};
      default: ext = membus.rdata[XLEN-1:0];
    endcase
    rdata = '0;
    if (state_q == StWaitValid && membus.rvalid && !wen_q) rdata = ext;
  end

endmodule

// File: tb/tb_memunit.sv
// Randomized self-checking bench for memunit: a cycle-stepped responder with random
// wait states, checked against a size/offset arithmetic reference model.
module tb_memunit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, error;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  memunit_if #(.XLEN(32), .MEM_DATA_WIDTH(32)) bus ();

  memunit #(.XLEN(32), .MEM_DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .is_load  (is_load),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .rdata    (rdata),
    .error    (error),
    .membus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: access size in bytes, legality as natural alignment
  function automatic int ref_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] a);
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return (a % ref_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] ref_mask(input bit st, input logic [2:0] f3,
                                           input logic [31:0] a);
    int m;
    if (!st) return 32'd0;
    m = ((1 << ref_size(f3)) - 1) << (a % 4);
    return 32'(m & 15);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (ref_size(f3))
      1:       return (wd & 32'hFF) * 32'h0101_0101;
      2:       return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] ref_rdata(input bit st, input logic [2:0] f3,
                                            input logic [31:0] a, input logic [31:0] word);
    longint v;
    int     bits;
    if (st) return 32'd0;
    bits = 8 * ref_size(f3);
    v = longint'(word) >> (8 * (a % 4));
    v = v & ((64'd1 << bits) - 1);
    if (f3[2] == 1'b0 && bits < 32 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return 32'(v);
  endfunction

  task automatic run_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] word, input int rdly, input int vdly);
    bit legal;
    legal = ref_legal(f3, a);
    @(negedge clk);
    valid = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata = wd;
    bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = $urandom;
    #1;
    if (!legal) begin
      check("err_pulse", 32'(error), 32'd1);
      check("err_stall", 32'(stall), 32'd0);
      check("err_bvalid", 32'(bus.valid), 32'd0);
      @(negedge clk);
      valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
      #1;
      check("err_clear", 32'(error), 32'd0);
      check("err_idle_bvalid", 32'(bus.valid), 32'd0);
      return;
    end
    check("req_stall", 32'(stall), 32'd1);
    check("req_error", 32'(error), 32'd0);
    check("req_bvalid", 32'(bus.valid), 32'd0);
    for (int i = 0; i <= rdly; i++) begin
      @(negedge clk);
      bus.ready  = (i == rdly);
      bus.rvalid = 1'($urandom_range(0, 1));
      bus.rdata  = $urandom;
      #1;
      check("wr_bvalid", 32'(bus.valid), 32'd1);
      check("wr_stall", 32'(stall), 32'd1);
      check("wr_addr", bus.addr, a & 32'hFFFF_FFFC);
      check("wr_wen", 32'(bus.wen), 32'(st));
      check("wr_wmask", 32'(bus.wmask), ref_mask(st, f3, a));
      if (st) check("wr_wdata", bus.wdata, ref_wdata(f3, wd));
    end
    for (int j = 0; j <= vdly; j++) begin
      @(negedge clk);
      bus.ready  = 1'($urandom_range(0, 1));
      bus.rvalid = (j == vdly);
      bus.rdata  = (j == vdly) ? word : $urandom;
      #1;
      check("wv_bvalid", 32'(bus.valid), 32'd0);
      check("wv_stall", 32'(stall), 32'(j != vdly));
      if (j == vdly) check("rdata", rdata, ref_rdata(st, f3, a, word));
    end
    @(negedge clk);
    valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    bus.ready = 1'b0; bus.rvalid = 1'b0;
    #1;
    check("done_stall", 32'(stall), 32'd0);
    check("done_bvalid", 32'(bus.valid), 32'd0);
  endtask

  initial begin
    rst = 1'b0; valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'd0; addr = '0; wdata = '0;
    bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bvalid", 32'(bus.valid), 32'd0);
    check("rst_addr", bus.addr, 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_wmask", 32'(bus.wmask), 32'd0);
    check("rst_wen", 32'(bus.wen), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_op(1'b1, 1'b0, 3'b010, 32'h1000, 32'h0, 32'hDEAD_BEEF, 0, 0);
    run_op(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0);
    run_op(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 32'h80FF_0000, 0, 0);
    run_op(1'b0, 1'b1, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0, 0, 0);
    run_op(1'b0, 1'b1, 3'b000, 32'h2001, 32'h0000_0055, 32'h0, 0, 0);
    run_op(1'b1, 1'b0, 3'b010, 32'h1002, 32'h0, 32'h0, 0, 0);
    run_op(1'b1, 1'b0, 3'b011, 32'h1000, 32'h0, 32'h0, 0, 0);
    run_op(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h1234_5678, 3, 2);

    // Reset abandons an in-flight request; a stray rvalid afterwards does nothing
    @(negedge clk);
    valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h3000;
    bus.ready = 1'b0; bus.rvalid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_bvalid", 32'(bus.valid), 32'd1);
    rst = 1'b0; valid = 1'b0; is_load = 1'b0;
    #1;
    check("mid_rst_bvalid", 32'(bus.valid), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_addr", bus.addr, 32'd0);
    @(negedge clk);
    rst = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hFFFF_FFFF;
    #1;
    check("stray_stall", 32'(stall), 32'd0);
    check("stray_rdata", rdata, 32'd0);
    check("stray_bvalid", 32'(bus.valid), 32'd0);
    @(negedge clk);
    bus.rvalid = 1'b0;
    #1;
    check("post_rst_bvalid", 32'(bus.valid), 32'd0);
    run_op(1'b1, 1'b0, 3'b101, 32'h3002, 32'h0, 32'h8001_7FFF, 1, 1);

    for (int k = 0; k < 200; k++) begin
      bit          ld;
      logic [2:0]  f3;
      logic [31:0] a;
      ld = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0:       f3 = 3'b000;
          1:       f3 = 3'b001;
          2:       f3 = 3'b010;
          3:       f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      if (!ld && f3[2]) f3[2] = 1'b0;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      run_op(ld, !ld, f3, a, $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
